vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 57 +++++
 rtl/vga_timing_gen_if.sv | 33 +++
 rtl/vga_axis_counter.sv | 76 +++++++
 rtl/vga_timing_gen.sv | 112 +++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: axis phase enumeration, default 640x480
// timing constants and the position-to-phase decode used by both axes.
package vga_pkg;

    typedef enum logic [2:0] {
        PH_DISPLAY = 3'd0,
        PH_BORDER1 = 3'd1,
        PH_FRONT   = 3'd2,
        PH_SYNC    = 3'd3,
        PH_BACK    = 3'd4,
        PH_BORDER2 = 3'd5
    } phase_e;

    // Default 640x480 horizontal timing (pixels)
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_BORDER1 = 8;
    localparam int DEF_H_FRONT   = 8;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 40;
    localparam int DEF_H_BORDER2 = 8;

    // Default 640x480 vertical timing (lines)
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_BORDER1 = 8;
    localparam int DEF_V_FRONT   = 2;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 25;
    localparam int DEF_V_BORDER2 = 8;

    // Map a position on an axis to its phase. Zero-length phases drop out
    // naturally because their interval is empty.
    function automatic phase_e phase_of(
        input int pos,
        input int display_len,
        input int border1_len,
        input int front_len,
        input int sync_len,
        input int back_len
    );
        phase_e ph;
        if (pos < display_len) begin
            ph = PH_DISPLAY;
        end else if (pos < display_len + border1_len) begin
            ph = PH_BORDER1;
        end else if (pos < display_len + border1_len + front_len) begin
            ph = PH_FRONT;
        end else if (pos < display_len + border1_len + front_len + sync_len) begin
            ph = PH_SYNC;
        end else if (pos < display_len + border1_len + front_len + sync_len + back_len) begin
            ph = PH_BACK;
        end else begin
            ph = PH_BORDER2;
        end
        return ph;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: pixel enable in, sync/blanking/position/pulses out.
interface vga_timing_gen_if
    import vga_pkg::*;
#(
    parameter int CW = 10
) ();

    logic          pix_en;
    logic          vga_hs;
    logic          vga_vs;
    logic          de;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          line_start;
    logic          frame_start;
    phase_e        h_phase;
    phase_e        v_phase;

    // Timing generator side
    modport master (
        input  pix_en,
        output vga_hs, vga_vs, de, hcount, vcount,
               line_start, frame_start, h_phase, v_phase
    );

    // Display / consumer side
    modport slave (
        output pix_en,
        input  vga_hs, vga_vs, de, hcount, vcount,
               line_start, frame_start, h_phase, v_phase
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): position counter with registered
// phase and sync that always match the registered count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int CW          = 10,
    parameter int DISPLAY_LEN = 640,
    parameter int BORDER1_LEN = 8,
    parameter int FRONT_LEN   = 8,
    parameter int SYNC_LEN    = 96,
    parameter int BACK_LEN    = 40,
    parameter int BORDER2_LEN = 8,
    parameter bit SYNC_POL    = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] count,
    output phase_e        phase,
    output phase_e        next_phase,
    output logic          wrap,
    output logic          sync
);

    localparam int TOTAL = DISPLAY_LEN + BORDER1_LEN + FRONT_LEN + SYNC_LEN
                         + BACK_LEN + BORDER2_LEN;
    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    // Reject phase lengths that cannot be represented or are meaningless
    if (DISPLAY_LEN < 1 || SYNC_LEN < 1 || BORDER1_LEN < 0 || FRONT_LEN < 0 ||
        BACK_LEN < 0 || BORDER2_LEN < 0 || TOTAL > (1 << CW)) begin : g_param_check
        $error("vga_axis_counter: illegal phase lengths or total exceeds counter range");
    end

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    phase_e        phase_r;
    phase_e        phase_next_s;
    logic          sync_r;

    // Next position and the phase that position falls into
    always_comb begin
        count_next_s = count_r;
        if (step) begin
            if (count_r == LAST) begin
                count_next_s = {CW{1'b0}};
            end else begin
                count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            count_next_s = count_r;
        end
        phase_next_s = phase_of(int'(count_next_s), DISPLAY_LEN, BORDER1_LEN,
                                FRONT_LEN, SYNC_LEN, BACK_LEN);
    end

    // Count, phase and sync registered together so they never disagree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
            phase_r <= PH_DISPLAY;
            sync_r  <= ~SYNC_POL;
        end else begin
            count_r <= count_next_s;
            phase_r <= phase_next_s;
            sync_r  <= (phase_next_s == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign count      = count_r;
    assign phase      = phase_r;
    assign next_phase = phase_next_s;
    assign wrap       = (count_r == LAST);
    assign sync       = sync_r;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal and vertical axis counters chained on the
// line wrap, with registered display-enable and line/frame start pulses.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_BORDER1 = DEF_H_BORDER1,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int H_BORDER2 = DEF_H_BORDER2,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_BORDER1 = DEF_V_BORDER1,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int V_BORDER2 = DEF_V_BORDER2,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CW        = 10
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  bus
);

    logic [CW-1:0] h_count_s;
    logic [CW-1:0] v_count_s;
    phase_e        h_phase_s;
    phase_e        v_phase_s;
    phase_e        h_next_phase_s;
    phase_e        v_next_phase_s;
    logic          h_wrap_s;
    logic          v_wrap_s;
    logic          h_sync_s;
    logic          v_sync_s;
    logic          v_step_s;
    logic          de_r;
    logic          line_start_r;
    logic          frame_start_r;

    // The vertical axis moves only on the enabled edge that wraps the line
    assign v_step_s = bus.pix_en & h_wrap_s;

    vga_axis_counter #(
        .CW          (CW),
        .DISPLAY_LEN (H_DISPLAY),
        .BORDER1_LEN (H_BORDER1),
        .FRONT_LEN   (H_FRONT),
        .SYNC_LEN    (H_SYNC),
        .BACK_LEN    (H_BACK),
        .BORDER2_LEN (H_BORDER2),
        .SYNC_POL    (HS_POL)
    ) u_h_axis (
        .clk        (clk),
        .rst        (rst),
        .step       (bus.pix_en),
        .count      (h_count_s),
        .phase      (h_phase_s),
        .next_phase (h_next_phase_s),
        .wrap       (h_wrap_s),
        .sync       (h_sync_s)
    );

    vga_axis_counter #(
        .CW          (CW),
        .DISPLAY_LEN (V_DISPLAY),
        .BORDER1_LEN (V_BORDER1),
        .FRONT_LEN   (V_FRONT),
        .SYNC_LEN    (V_SYNC),
        .BACK_LEN    (V_BACK),
        .BORDER2_LEN (V_BORDER2),
        .SYNC_POL    (VS_POL)
    ) u_v_axis (
        .clk        (clk),
        .rst        (rst),
        .step       (v_step_s),
        .count      (v_count_s),
        .phase      (v_phase_s),
        .next_phase (v_next_phase_s),
        .wrap       (v_wrap_s),
        .sync       (v_sync_s)
    );

    // Display enable follows the phases being entered; pulses last one enabled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_r          <= 1'b1;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (bus.pix_en) begin
            de_r          <= (h_next_phase_s == PH_DISPLAY) && (v_next_phase_s == PH_DISPLAY);
            line_start_r  <= h_wrap_s;
            frame_start_r <= h_wrap_s & v_wrap_s;
        end else begin
            de_r          <= de_r;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

    assign bus.hcount      = h_count_s;
    assign bus.vcount      = v_count_s;
    assign bus.h_phase     = h_phase_s;
    assign bus.v_phase     = v_phase_s;
    assign bus.vga_hs      = h_sync_s;
    assign bus.vga_vs      = v_sync_s;
    assign bus.de          = de_r;
    assign bus.line_start  = line_start_r;
    assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations (default timing, a tiny
// timing with skipped phases, and an inverted-polarity tiny timing) each
// checked every cycle against a position-arithmetic model, plus literal pins.
module tb_vga_timing_gen;

    localparam int NI = 3;
    localparam int P_HD  [NI] = '{640, 1, 4};
    localparam int P_HB1 [NI] = '{8,   1, 0};
    localparam int P_HF  [NI] = '{8,   1, 2};
    localparam int P_HS  [NI] = '{96,  2, 3};
    localparam int P_HBK [NI] = '{40,  1, 0};
    localparam int P_HB2 [NI] = '{8,   1, 1};
    localparam int P_VD  [NI] = '{480, 2, 3};
    localparam int P_VB1 [NI] = '{8,   0, 1};
    localparam int P_VF  [NI] = '{2,   1, 0};
    localparam int P_VS  [NI] = '{2,   1, 2};
    localparam int P_VBK [NI] = '{25,  0, 1};
    localparam int P_VB2 [NI] = '{8,   0, 0};
    localparam bit P_POL [NI] = '{1'b0, 1'b0, 1'b1};
    localparam int P_CW  [NI] = '{10, 4, 5};

    logic clk = 1'b0;
    logic rst;
    logic pix_en;
    logic chk_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [9:0] o_hc [NI];
    logic [9:0] o_vc [NI];
    logic       o_hs [NI];
    logic       o_vs [NI];
    logic       o_de [NI];
    logic       o_ls [NI];
    logic       o_fs [NI];

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int HT  = P_HD[g] + P_HB1[g] + P_HF[g] + P_HS[g] + P_HBK[g] + P_HB2[g];
        localparam int VT  = P_VD[g] + P_VB1[g] + P_VF[g] + P_VS[g] + P_VBK[g] + P_VB2[g];
        localparam int HSS = P_HD[g] + P_HB1[g] + P_HF[g];
        localparam int VSS = P_VD[g] + P_VB1[g] + P_VF[g];

        vga_timing_gen_if #(.CW(P_CW[g])) bus ();

        vga_timing_gen #(
            .H_DISPLAY (P_HD[g]),  .H_BORDER1 (P_HB1[g]), .H_FRONT (P_HF[g]),
            .H_SYNC    (P_HS[g]),  .H_BACK    (P_HBK[g]), .H_BORDER2 (P_HB2[g]),
            .V_DISPLAY (P_VD[g]),  .V_BORDER1 (P_VB1[g]), .V_FRONT (P_VF[g]),
            .V_SYNC    (P_VS[g]),  .V_BACK    (P_VBK[g]), .V_BORDER2 (P_VB2[g]),
            .HS_POL    (P_POL[g]), .VS_POL    (P_POL[g]), .CW (P_CW[g])
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.pix_en = pix_en;
        assign o_hc[g] = 10'(bus.hcount);
        assign o_vc[g] = 10'(bus.vcount);
        assign o_hs[g] = bus.vga_hs;
        assign o_vs[g] = bus.vga_vs;
        assign o_de[g] = bus.de;
        assign o_ls[g] = bus.line_start;
        assign o_fs[g] = bus.frame_start;

        int mhc = 0;
        int mvc = 0;
        bit mls = 1'b0;
        bit mfs = 1'b0;

        // Reference position: raster scan over HT x VT, moving on enabled edges
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                mhc <= 0;
                mvc <= 0;
                mls <= 1'b0;
                mfs <= 1'b0;
            end else if (pix_en) begin
                mls <= (mhc == HT - 1);
                mfs <= (mhc == HT - 1) && (mvc == VT - 1);
                mhc <= (mhc == HT - 1) ? 0 : mhc + 1;
                if (mhc == HT - 1) mvc <= (mvc == VT - 1) ? 0 : mvc + 1;
            end else begin
                mls <= 1'b0;
                mfs <= 1'b0;
            end
        end

        // Compare every DUT output against the model on the falling edge
        always @(negedge clk) begin
            if (chk_en) begin
                check_eq($sformatf("i%0d hcount", g), int'(o_hc[g]), mhc);
                check_eq($sformatf("i%0d vcount", g), int'(o_vc[g]), mvc);
                check_eq($sformatf("i%0d de", g), int'(o_de[g]),
                         (mhc < P_HD[g] && mvc < P_VD[g]) ? 1 : 0);
                check_eq($sformatf("i%0d hs", g), int'(o_hs[g]),
                         (mhc >= HSS && mhc < HSS + P_HS[g]) ? int'(P_POL[g]) : 1 - int'(P_POL[g]));
                check_eq($sformatf("i%0d vs", g), int'(o_vs[g]),
                         (mvc >= VSS && mvc < VSS + P_VS[g]) ? int'(P_POL[g]) : 1 - int'(P_POL[g]));
                check_eq($sformatf("i%0d line_start", g), int'(o_ls[g]), int'(mls));
                check_eq($sformatf("i%0d frame_start", g), int'(o_fs[g]), int'(mfs));
            end
        end
    end

    initial begin
        int ls_first, ls_second, fs_first, fs_second;
        int hs_min, hs_max, hs1_min, hs1_max, de1_cnt, first_fs;
        bit found;

        rst = 1'b1;
        pix_en = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values, pinned literally
        check_eq("rst hcount", int'(o_hc[0]), 0);
        check_eq("rst vcount", int'(o_vc[0]), 0);
        check_eq("rst de", int'(o_de[0]), 1);
        check_eq("rst hs pol0", int'(o_hs[0]), 1);
        check_eq("rst vs pol0", int'(o_vs[0]), 1);
        check_eq("rst hs pol1", int'(o_hs[2]), 0);
        check_eq("rst vs pol1", int'(o_vs[2]), 0);
        check_eq("rst line_start", int'(o_ls[0]), 0);
        check_eq("rst frame_start", int'(o_fs[1]), 0);

        // Release with continuous enable
        rst = 1'b0;
        pix_en = 1'b1;
        @(negedge clk);
        check_eq("first hcount i0", int'(o_hc[0]), 1);
        check_eq("first hcount i1", int'(o_hc[1]), 1);

        ls_first = -1; ls_second = -1; fs_first = -1; fs_second = -1;
        hs_min = 9999; hs_max = -1; hs1_min = 9999; hs1_max = -1; de1_cnt = 0;
        for (int c = 2; c <= 2000; c++) begin
            @(negedge clk);
            if (o_ls[0]) begin
                if (ls_first < 0) ls_first = c;
                else if (ls_second < 0) ls_second = c;
            end
            if (o_fs[1]) begin
                if (fs_first < 0) fs_first = c;
                else if (fs_second < 0) fs_second = c;
            end
            if (o_hs[0] == 1'b0) begin
                if (int'(o_hc[0]) < hs_min) hs_min = int'(o_hc[0]);
                if (int'(o_hc[0]) > hs_max) hs_max = int'(o_hc[0]);
            end
            if (o_hs[1] == 1'b0) begin
                if (int'(o_hc[1]) < hs1_min) hs1_min = int'(o_hc[1]);
                if (int'(o_hc[1]) > hs1_max) hs1_max = int'(o_hc[1]);
            end
            if (c >= 28 && c <= 55 && o_de[1]) de1_cnt++;
        end
        check_eq("default first line_start edge", ls_first, 800);
        check_eq("default line length", ls_second - ls_first, 800);
        check_eq("default hs first count", hs_min, 656);
        check_eq("default hs last count", hs_max, 751);
        check_eq("tiny first frame_start edge", fs_first, 28);
        check_eq("tiny frame period", fs_second - fs_first, 28);
        check_eq("tiny hs first count", hs1_min, 3);
        check_eq("tiny hs last count", hs1_max, 4);
        check_eq("tiny de per frame", de1_cnt, 2);

        // Enable toggling every clock halves the pixel rate
        ls_first = -1; ls_second = -1;
        for (int n = 0; n < 3400; n++) begin
            pix_en = (n % 2 == 0);
            @(negedge clk);
            if (o_ls[0]) begin
                if (ls_first < 0) ls_first = n;
                else if (ls_second < 0) ls_second = n;
            end
        end
        check_eq("toggled line length", ls_second - ls_first, 1600);

        // Random enable pattern, checked by the model
        for (int n = 0; n < 3000; n++) begin
            pix_en = 1'($urandom_range(0, 1));
            @(negedge clk);
        end

        // Mid-line reset while running
        pix_en = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 900 && !found; n++) begin
            @(negedge clk);
            if (o_hc[0] == 10'd700) found = 1'b1;
        end
        check_eq("reached hcount 700", int'(found), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("async rst hcount", int'(o_hc[0]), 0);
        check_eq("async rst vcount", int'(o_vc[0]), 0);
        check_eq("async rst de", int'(o_de[0]), 1);
        check_eq("async rst hs pol0", int'(o_hs[0]), 1);
        check_eq("async rst hs pol1", int'(o_hs[2]), 0);
        check_eq("async rst vs pol1", int'(o_vs[2]), 0);
        check_eq("async rst line_start", int'(o_ls[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        first_fs = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) check_eq("post-rst hcount", int'(o_hc[0]), 1);
            if (o_fs[1] && first_fs < 0) first_fs = n;
        end
        check_eq("post-rst first frame_start", first_fs, 28);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
